// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch / phase-control stage; retired counter under INSTR_COUNT_EN
module fetch_sequencer #(
    parameter int IR_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             i_CLOCK,
    input  logic             i_RESETn,
    input  logic [1:0]       i_PHASE,
    input  logic             i_HALT,
    input  logic             i_MEM_READY,
    input  logic [IR_W-1:0]  i_MEM_DATA,
    output logic             o_MEM_REQ,
    output logic [IR_W-1:0]  o_IR,
    output logic             o_DECODE_EN,
    output logic             o_EXEC_EN,
    output logic             o_PC_INC,
    output logic             o_STALL,
    output logic             o_HALTED,
    output logic [CNT_W-1:0] o_RETIRED
);

    typedef enum logic [0:0] {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      prev_phase_q;
    logic            busy_q, busy_d;
    logic            pending_q, pending_d;
    logic            decoded_q, decoded_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            decode_q, decode_d;
    logic            exec_q, exec_d;
    logic            stall_q, stall_d;

    logic p1_entry, p2_entry, p3_entry, handshake;

    // An entry is the first edge of a phase; phase 0 never matches.
    assign p1_entry  = (i_PHASE == 2'd1) && (prev_phase_q != 2'd1);
    assign p2_entry  = (i_PHASE == 2'd2) && (prev_phase_q != 2'd2);
    assign p3_entry  = (i_PHASE == 2'd3) && (prev_phase_q != 2'd3);
    assign handshake = busy_q && i_MEM_READY;

    always_ff @(posedge i_CLOCK) begin
        if (!i_RESETn) begin
            state_q      <= ST_RUN;
            prev_phase_q <= 2'd0;
            busy_q       <= 1'b0;
            pending_q    <= 1'b0;
            decoded_q    <= 1'b0;
            ir_q         <= '0;
            decode_q     <= 1'b0;
            exec_q       <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_phase_q <= i_PHASE;
            busy_q       <= busy_d;
            pending_q    <= pending_d;
            decoded_q    <= decoded_d;
            ir_q         <= ir_d;
            decode_q     <= decode_d;
            exec_q       <= exec_d;
            stall_q      <= stall_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        pending_d = pending_q;
        decoded_d = decoded_q;
        ir_d      = ir_q;
        decode_d  = 1'b0;
        exec_d    = 1'b0;
        stall_d   = busy_q && (i_PHASE != 2'd1);

        // busy and pending are mutually exclusive, so the handshake never
        // collides with a fetch start or a decode on the same edge.
        if (handshake) begin
            ir_d      = i_MEM_DATA;
            pending_d = 1'b1;
            busy_d    = 1'b0;
        end

        if (p1_entry) begin
            case (state_q)
                ST_RUN: begin
                    if (i_HALT && !busy_q) begin
                        state_d = ST_HALTED;
                    end else if (!busy_q && !pending_q) begin
                        busy_d = 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!i_HALT) begin
                        state_d = ST_RUN;
                        if (!pending_q) begin
                            busy_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        if (p2_entry && pending_q) begin
            decode_d  = 1'b1;
            pending_d = 1'b0;
            decoded_d = 1'b1;
        end

        if (p3_entry && decoded_q) begin
            exec_d    = 1'b1;
            decoded_d = 1'b0;
        end
    end

    assign o_MEM_REQ   = busy_q;
    assign o_IR        = ir_q;
    assign o_DECODE_EN = decode_q;
    assign o_EXEC_EN   = exec_q;
    assign o_PC_INC    = exec_q;
    assign o_STALL     = stall_q;
    assign o_HALTED    = (state_q == ST_HALTED);

`ifdef INSTR_COUNT_EN
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge i_CLOCK) begin
        if (!i_RESETn) begin
            retired_q <= '0;
        end else if (exec_d) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign o_RETIRED = retired_q;
`else
    assign o_RETIRED = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam int IR_W  = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [1:0]       phase = 2'd0;
    logic             halt = 1'b0;
    logic             rdy = 1'b0;
    logic [IR_W-1:0]  data = '0;
    logic             mem_req;
    logic [IR_W-1:0]  ir;
    logic             decode_en;
    logic             exec_en;
    logic             pc_inc;
    logic             stall;
    logic             halted;
    logic [CNT_W-1:0] retired;

    fetch_sequencer #(.IR_W(IR_W), .CNT_W(CNT_W)) dut (
        .i_CLOCK     (clk),
        .i_RESETn    (resetn),
        .i_PHASE     (phase),
        .i_HALT      (halt),
        .i_MEM_READY (rdy),
        .i_MEM_DATA  (data),
        .o_MEM_REQ   (mem_req),
        .o_IR        (ir),
        .o_DECODE_EN (decode_en),
        .o_EXEC_EN   (exec_en),
        .o_PC_INC    (pc_inc),
        .o_STALL     (stall),
        .o_HALTED    (halted),
        .o_RETIRED   (retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int n_req, n_dec, n_exec, n_pc, n_stall;
    int dec_phase, exec_phase;
    int exp_ret = 0;
    logic [IR_W-1:0] exp_ir[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ret_exp();
`ifdef INSTR_COUNT_EN
        return 32'(exp_ret & ((1 << CNT_W) - 1));
`else
        return 32'd0;
`endif
    endfunction

    // One clock; outputs are observed on the falling edge, decoded words popped from the scoreboard.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (mem_req) n_req++;
        if (stall) n_stall++;
        if (pc_inc) n_pc++;
        if (exec_en) begin
            n_exec++;
            exec_phase = int'(phase);
        end
        if (decode_en) begin
            n_dec++;
            dec_phase = int'(phase);
            if (exp_ir.size() == 0) chk("unexpected_decode", 32'(ir), 32'hffff_ffff);
            else chk("ir_at_decode", 32'(ir), 32'(exp_ir.pop_front()));
        end
    endtask

    // Phases 1,2,3 for two cycles each; ready is high from cycle index rdy_from onward.
    task automatic round(input int rdy_from, input logic [IR_W-1:0] d);
        n_req = 0; n_dec = 0; n_exec = 0; n_pc = 0; n_stall = 0;
        dec_phase = 0; exec_phase = 0;
        for (int k = 0; k < 6; k++) begin
            phase = 2'(k / 2 + 1);
            rdy   = (k >= rdy_from);
            data  = d;
            cyc();
        end
        rdy = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},     32'(mem_req),   0);
        chk({tag, "_ir"},      32'(ir),        0);
        chk({tag, "_dec"},     32'(decode_en), 0);
        chk({tag, "_exec"},    32'(exec_en),   0);
        chk({tag, "_pc"},      32'(pc_inc),    0);
        chk({tag, "_stall"},   32'(stall),     0);
        chk({tag, "_halted"},  32'(halted),    0);
        chk({tag, "_retired"}, 32'(retired),   0);
    endtask

    task automatic do_reset();
        resetn = 1'b0; phase = 2'd0; rdy = 1'b0; halt = 1'b0;
        cyc();
        resetn = 1'b1;
        exp_ret = 0;
        exp_ir.delete();
    endtask

    initial begin
        // Basic round with immediate ready.
        do_reset();
        chk_zero("reset");
        exp_ir.push_back(16'hA5C3);
        round(0, 16'hA5C3);
        exp_ret = 1;
        chk("t1_req_cycles", n_req, 1);
        chk("t1_ir", 32'(ir), 32'hA5C3);
        chk("t1_dec", n_dec, 1);
        chk("t1_dec_phase", dec_phase, 2);
        chk("t1_exec", n_exec, 1);
        chk("t1_exec_phase", exec_phase, 3);
        chk("t1_pc", n_pc, 1);
        chk("t1_retired", 32'(retired), ret_exp());

        // Ready arrives late in phase 3: round skipped, held word runs next round.
        do_reset();
        exp_ir.push_back(16'h1111);
        round(5, 16'h1111);
        chk("t2_r1_req", n_req, 5);
        chk("t2_r1_stall", n_stall, 4);
        chk("t2_r1_dec", n_dec, 0);
        chk("t2_r1_exec", n_exec, 0);
        round(6, 16'h0);
        exp_ret = 1;
        chk("t2_r2_req", n_req, 0);
        chk("t2_r2_dec", n_dec, 1);
        chk("t2_r2_exec", n_exec, 1);
        chk("t2_retired", 32'(retired), ret_exp());

        // Ready on the phase-2 entry edge: latched but decoded a round later.
        do_reset();
        exp_ir.push_back(16'h2222);
        round(2, 16'h2222);
        chk("t3_r1_req", n_req, 2);
        chk("t3_r1_ir", 32'(ir), 32'h2222);
        chk("t3_r1_dec", n_dec, 0);
        chk("t3_r1_exec", n_exec, 0);
        round(6, 16'h0);
        exp_ret = 1;
        chk("t3_r2_req", n_req, 0);
        chk("t3_r2_dec", n_dec, 1);
        chk("t3_r2_exec", n_exec, 1);

        // Halt for three rounds, then release.
        do_reset();
        halt = 1'b1;
        for (int r = 0; r < 3; r++) begin
            round(0, 16'h3333);
            chk("t4_halted", 32'(halted), 1);
            chk("t4_req", n_req, 0);
            chk("t4_dec", n_dec, 0);
        end
        halt = 1'b0;
        exp_ir.push_back(16'h4444);
        round(0, 16'h4444);
        exp_ret = 1;
        chk("t4_rel_halted", 32'(halted), 0);
        chk("t4_rel_req", n_req, 1);
        chk("t4_rel_exec", n_exec, 1);
        chk("t4_retired", 32'(retired), ret_exp());

        // Reset while a fetch is outstanding.
        do_reset();
        exp_ir.push_back(16'h1234);
        round(0, 16'h1234);
        phase = 2'd1; rdy = 1'b0;
        cyc();
        cyc();
        chk("t5_pre_req", 32'(mem_req), 1);
        chk("t5_pre_ir", 32'(ir), 32'h1234);
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        exp_ret = 0;
        chk_zero("t5_reset");
        exp_ir.push_back(16'h5A5A);
        round(0, 16'h5A5A);
        exp_ret = 1;
        chk("t5_req", n_req, 1);
        chk("t5_dec", n_dec, 1);
        chk("t5_ir", 32'(ir), 32'h5A5A);

        // Seventeen rounds wrap the 4-bit counter.
        do_reset();
        for (int r = 0; r < 17; r++) begin
            exp_ir.push_back(16'(r + 16'h100));
            round(0, 16'(r + 16'h100));
            exp_ret++;
            chk("t6_exec", n_exec, 1);
            chk("t6_retired", 32'(retired), ret_exp());
        end
        chk("t6_final_retired", 32'(retired), ret_exp());
        chk("scoreboard_empty", exp_ir.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
